// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the LCD bus scheduler.
package lcd_bus_pkg;

    localparam int LCD_DW = 18;

    // Default frame-start command (memory write).
    localparam logic [LCD_DW-1:0] LCD_CMD_RAMWR = 18'h02C;

    // Bus cycle phases.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

endpackage

// File: rtl/lcd_strobe_timer.sv
// Loadable down-counter timing the STROBE and RECOVER phases.
// done is high in the last cycle of the loaded duration.
module lcd_strobe_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Reload on phase entry, otherwise count down and rest at one.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt > ONE) begin
            cnt <= cnt - ONE;
        end
    end

    assign done = (cnt <= ONE);

endmodule

// File: rtl/lcd_bus_sched.sv
// LCD bus scheduler: shares the 18-bit parallel LCD bus between a CPU
// register port and a pixel stream, inserts the frame-start command before
// each frame and bounds pixel bursts while the CPU waits.
// Optional: define LCD_TE_SYNC_EN to hold each frame-start command until a
// synchronised rising edge of lcd_fmark has been seen.
module lcd_bus_sched
    import lcd_bus_pkg::*;
#(
    parameter int WR_LOW    = 1,
    parameter int WR_HIGH   = 1,
    parameter int RD_LOW    = 4,
    parameter int MAX_BURST = 64,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stream_en,
    input  logic [LCD_DW-1:0] start_cmd,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_rs,
    input  logic [LCD_DW-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [LCD_DW-1:0] cpu_rdata,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [LCD_DW-1:0] pix_data,
    output logic              pix_ready,
    input  logic              lcd_fmark,
    output logic [LCD_DW-1:0] lcd_db_out,
    output logic              lcd_db_oe,
    input  logic [LCD_DW-1:0] lcd_db_in,
    output logic              lcd_rs,
    output logic              lcd_wr,
    output logic              lcd_rd,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WR_LOW_C    = CNT_W'(WR_LOW);
    localparam logic [CNT_W-1:0] WR_HIGH_C   = CNT_W'(WR_HIGH);
    localparam logic [CNT_W-1:0] RD_LOW_C    = CNT_W'(RD_LOW);
    localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

    state_t           state, state_n;
    logic             cur_we;      // current transfer is a write
    logic             cur_cpu;     // current transfer belongs to the CPU
    logic [CNT_W-1:0] burst_cnt;
    logic             cmd_sent;
    logic             send_cmd;
    logic             pix_win;
    logic             cpu_win;
    logic             te_ok;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

`ifdef LCD_TE_SYNC_EN
    logic fm_s1, fm_s2, fm_s3;
    logic te_seen;
    logic te_rise;

    assign te_rise = fm_s2 & ~fm_s3;
    assign te_ok   = te_seen | te_rise;

    // Synchronise the tearing-effect input and remember a rising edge until
    // the frame-start command is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fm_s1   <= 1'b0;
            fm_s2   <= 1'b0;
            fm_s3   <= 1'b0;
            te_seen <= 1'b0;
        end else begin
            fm_s1 <= lcd_fmark;
            fm_s2 <= fm_s1;
            fm_s3 <= fm_s2;
            if (pix_win && send_cmd) begin
                te_seen <= 1'b0;
            end else if (te_rise) begin
                te_seen <= 1'b1;
            end
        end
    end
`else
    wire unused_fmark = lcd_fmark;
    assign te_ok = 1'b1;
`endif

    // Arbitration, evaluated only while the bus is idle.
    always_comb begin
        send_cmd = pix_sof && !cmd_sent;
        pix_win  = (state == IDLE) && stream_en && pix_valid
                   && (!send_cmd || te_ok)
                   && (!cpu_req || (burst_cnt < MAX_BURST_C));
        cpu_win  = (state == IDLE) && cpu_req && !pix_win;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, timer control and single-cycle handshakes.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        pix_ready = 1'b0;
        cpu_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (pix_win || cpu_win) begin
                    state_n = SETUP;
                end
                pix_ready = pix_win && !send_cmd;
            end
            SETUP: begin
                state_n  = STROBE;
                tmr_load = 1'b1;
                tmr_val  = cur_we ? WR_LOW_C : RD_LOW_C;
            end
            STROBE: begin
                if (tmr_done) begin
                    state_n  = RECOVER;
                    tmr_load = 1'b1;
                    tmr_val  = WR_HIGH_C;
                end
            end
            RECOVER: begin
                if (tmr_done) begin
                    state_n = IDLE;
                    cpu_ack = cur_cpu;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    lcd_strobe_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Bus drive registers: latched at grant, strobes decoded from next state
    // so they come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_rs     <= 1'b0;
            lcd_db_out <= '0;
            lcd_db_oe  <= 1'b0;
            lcd_wr     <= 1'b1;
            lcd_rd     <= 1'b1;
            cur_we     <= 1'b0;
            cur_cpu    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            if (pix_win) begin
                lcd_rs     <= !send_cmd;
                lcd_db_out <= send_cmd ? start_cmd : pix_data;
                lcd_db_oe  <= 1'b1;
                cur_we     <= 1'b1;
                cur_cpu    <= 1'b0;
            end else if (cpu_win) begin
                lcd_rs     <= cpu_rs;
                lcd_db_out <= cpu_we ? cpu_wdata : '0;
                lcd_db_oe  <= cpu_we;
                cur_we     <= cpu_we;
                cur_cpu    <= 1'b1;
            end else if (state == RECOVER && tmr_done) begin
                lcd_db_oe  <= 1'b0;
            end
            lcd_wr <= !((state_n == STROBE) && cur_we);
            lcd_rd <= !((state_n == STROBE) && !cur_we);
            if (state == STROBE && tmr_done && !cur_we) begin
                cpu_rdata <= lcd_db_in;
            end
        end
    end

    // Burst accounting and frame-start tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
            cmd_sent  <= 1'b0;
        end else begin
            if (!cpu_req || cpu_win) begin
                burst_cnt <= '0;
            end else if (pix_win && burst_cnt != MAX_BURST_C) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (pix_win) begin
                cmd_sent <= send_cmd;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Self-checking bench for lcd_bus_sched: a bus monitor compares every strobe
// and every cpu_ack against scoreboard queues filled as stimulus is driven.
`timescale 1ns/1ps
module tb_lcd_bus_sched;
    import lcd_bus_pkg::*;

    localparam int WR_LOW    = 1;
    localparam int WR_HIGH   = 1;
    localparam int RD_LOW    = 4;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stream_en = 1'b0;
    logic [LCD_DW-1:0] start_cmd = LCD_CMD_RAMWR;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic              cpu_rs = 1'b0;
    logic [LCD_DW-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic [LCD_DW-1:0] cpu_rdata;
    logic              pix_valid = 1'b0;
    logic              pix_sof = 1'b0;
    logic [LCD_DW-1:0] pix_data = '0;
    logic              pix_ready;
    logic              lcd_fmark = 1'b0;
    logic [LCD_DW-1:0] lcd_db_out;
    logic              lcd_db_oe;
    logic [LCD_DW-1:0] lcd_db_in = '0;
    logic              lcd_rs;
    logic              lcd_wr;
    logic              lcd_rd;
    logic              busy;

    lcd_bus_sched #(
        .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH), .RD_LOW(RD_LOW),
        .MAX_BURST(MAX_BURST), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .stream_en(stream_en), .start_cmd(start_cmd),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_rs(cpu_rs), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
        .lcd_fmark(lcd_fmark), .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe),
        .lcd_db_in(lcd_db_in), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rd;
        logic              rs;
        logic [LCD_DW-1:0] d;
    } bus_t;

    typedef struct packed {
        logic              rd;
        logic [LCD_DW-1:0] d;
    } ack_t;

    bus_t exp_bus[$];
    ack_t exp_ack[$];

    int checks = 0;
    int failures = 0;
    int pix_cnt = 0;
    int bus_starts = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void push_bus(input logic rd, input logic rs, input logic [LCD_DW-1:0] d);
        bus_t e;
        e.rd = rd;
        e.rs = rs;
        e.d  = d;
        exp_bus.push_back(e);
    endfunction

    function automatic void push_ack(input logic rd, input logic [LCD_DW-1:0] d);
        ack_t e;
        e.rd = rd;
        e.d  = d;
        exp_ack.push_back(e);
    endfunction

    // Bus monitor: samples on the falling clock edge.
    logic              prev_wr = 1'b1;
    logic              prev_rd = 1'b1;
    logic              cur_rd = 1'b0;
    logic [LCD_DW:0]   cur_bus = '0;
    int                low_cnt = 0;

    always @(negedge clk) begin
        bus_t eb;
        ack_t ea;
        if (rst) begin
            prev_wr = 1'b1;
            prev_rd = 1'b1;
            low_cnt = 0;
        end else begin
            if ((lcd_wr && !prev_wr) || (lcd_rd && !prev_rd))
                check(cur_rd ? "rd_width" : "wr_width", low_cnt, cur_rd ? RD_LOW : WR_LOW);
            if ((!lcd_wr && prev_wr) || (!lcd_rd && prev_rd)) begin
                bus_starts++;
                cur_rd  = !lcd_rd;
                cur_bus = {lcd_rs, lcd_db_out};
                low_cnt = 1;
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected", 1, 0);
                end else begin
                    eb = exp_bus.pop_front();
                    check("bus_dir", cur_rd, eb.rd);
                    check("bus_rs", lcd_rs, eb.rs);
                    check("bus_oe", lcd_db_oe, !eb.rd);
                    if (!eb.rd) check("bus_data", lcd_db_out, eb.d);
                end
            end else if (!lcd_wr || !lcd_rd) begin
                low_cnt++;
                check("bus_stable", {lcd_rs, lcd_db_out}, cur_bus);
            end
            if (cpu_ack) begin
                if (exp_ack.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    ea = exp_ack.pop_front();
                    if (ea.rd) check("ack_rdata", cpu_rdata, ea.d);
                end
            end
            if (pix_ready) pix_cnt++;
            prev_wr = lcd_wr;
            prev_rd = lcd_rd;
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        check("idle_reached", busy, 0);
    endtask

    task automatic cpu_xfer(input logic we, input logic rs, input logic [LCD_DW-1:0] wd,
                            input logic [LCD_DW-1:0] rd_exp, input logic push);
        int n = 0;
        if (push) push_bus(!we, rs, wd);
        push_ack(!we, rd_exp);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_rs = rs; cpu_wdata = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ack && n < 300);
        check("cpu_ack_seen", cpu_ack, 1);
        cpu_req = 1'b0;
    endtask

    task automatic send_pixels(input int n, input logic [LCD_DW-1:0] base, input logic first_sof);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            @(posedge clk); #1;
            stream_en = 1'b1;
            pix_valid = 1'b1;
            pix_sof   = (i == 0) && first_sof;
            pix_data  = base + LCD_DW'(i);
            do begin
                @(negedge clk);
                w++;
            end while (!pix_ready && w < 300);
            check("pix_ready_seen", pix_ready, 1);
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    // Provides the tearing-effect edge a frame start needs when the option is built in.
    task automatic te_kick();
`ifdef LCD_TE_SYNC_EN
        lcd_fmark = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_fmark = 1'b0;
`endif
    endtask

    initial begin
        int p0;
        int s0;
        int n;

        // Reset values.
        @(negedge clk);
        check("rst_wr", lcd_wr, 1);
        check("rst_rd", lcd_rd, 1);
        check("rst_rs", lcd_rs, 0);
        check("rst_db", lcd_db_out, 0);
        check("rst_oe", lcd_db_oe, 0);
        check("rst_ack", cpu_ack, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CPU write, cycle by cycle.
        push_bus(1'b0, 1'b1, 18'h3FFFF);
        push_ack(1'b0, '0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_rs = 1'b1; cpu_wdata = 18'h3FFFF;
        @(negedge clk);
        check("w_grant_busy", busy, 0);
        @(negedge clk);
        check("w_setup_busy", busy, 1);
        check("w_setup_wr", lcd_wr, 1);
        check("w_setup_db", lcd_db_out, 18'h3FFFF);
        check("w_setup_rs", lcd_rs, 1);
        @(negedge clk);
        check("w_strobe_wr", lcd_wr, 0);
        check("w_strobe_ack", cpu_ack, 0);
        @(negedge clk);
        check("w_recover_wr", lcd_wr, 1);
        check("w_recover_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        @(negedge clk);
        check("w_done_busy", busy, 0);
        check("w_done_ack", cpu_ack, 0);

        // CPU read.
        lcd_db_in = 18'h00ABC;
        cpu_xfer(1'b0, 1'b0, '0, 18'h00ABC, 1'b1);
        wait_idle();
        lcd_db_in = 18'h15555;
        cpu_xfer(1'b0, 1'b1, '0, 18'h15555, 1'b1);
        wait_idle();

        // Frame of three pixels with a frame-start command.
        start_cmd = LCD_CMD_RAMWR;
        push_bus(1'b0, 1'b0, LCD_CMD_RAMWR);
        for (int i = 0; i < 3; i++) push_bus(1'b0, 1'b1, 18'h10001 + LCD_DW'(i));
        p0 = pix_cnt;
        te_kick();
        send_pixels(3, 18'h10001, 1'b1);
        wait_idle();
        check("frame_pix_ready_count", pix_cnt - p0, 3);

        // pix_valid with the stream disabled is ignored.
        p0 = pix_cnt;
        s0 = bus_starts;
        @(posedge clk); #1;
        stream_en = 1'b0; pix_valid = 1'b1; pix_data = 18'h0BEEF;
        repeat (8) @(negedge clk);
        check("dis_pix_ready", pix_cnt - p0, 0);
        check("dis_bus_idle", bus_starts - s0, 0);
        pix_valid = 1'b0;

        // Stream disabled while the frame-start command is on the bus.
        start_cmd = 18'h2A5A5;
        push_bus(1'b0, 1'b0, 18'h2A5A5);
        te_kick();
        p0 = pix_cnt;
        @(posedge clk); #1;
        stream_en = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 18'h0CAFE;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 50);
        check("cmd_granted", busy, 1);
        @(posedge clk); #1;
        stream_en = 1'b0;
        repeat (8) @(negedge clk);
        check("cmd_no_pix_ready", pix_cnt - p0, 0);
        check("cmd_done_idle", busy, 0);
        push_bus(1'b0, 1'b1, 18'h0CAFE);
        @(posedge clk); #1;
        stream_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_ready && n < 50);
        check("cmd_held_pix_ready", pix_ready, 1);
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
        wait_idle();

        // Bounded burst: four pixels, then the CPU, then pixels resume.
        for (int i = 0; i < 4; i++) push_bus(1'b0, 1'b1, 18'h20000 + LCD_DW'(i));
        push_bus(1'b0, 1'b0, 18'h01234);
        for (int i = 4; i < 6; i++) push_bus(1'b0, 1'b1, 18'h20000 + LCD_DW'(i));
        p0 = pix_cnt;
        fork
            send_pixels(6, 18'h20000, 1'b0);
            cpu_xfer(1'b1, 1'b0, 18'h01234, '0, 1'b0);
        join
        wait_idle();
        check("burst_pix_ready_count", pix_cnt - p0, 6);

        // Reset in the middle of a write strobe.
        push_bus(1'b0, 1'b1, 18'h0F0F0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_rs = 1'b1; cpu_wdata = 18'h0F0F0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lcd_wr && n < 50);
        check("abort_strobe_seen", lcd_wr, 0);
        #2 rst = 1'b1;
        #1;
        check("abort_wr_async", lcd_wr, 1);
        check("abort_busy", busy, 0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_oe", lcd_db_oe, 0);
        check("abort_db", lcd_db_out, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cpu_xfer(1'b1, 1'b0, 18'h3C3C3, '0, 1'b1);
        wait_idle();

`ifdef LCD_TE_SYNC_EN
        // Frame start waits for a synchronised tearing-effect edge.
        start_cmd = LCD_CMD_RAMWR;
        push_bus(1'b0, 1'b0, LCD_CMD_RAMWR);
        push_bus(1'b0, 1'b1, 18'h30000);
        s0 = bus_starts;
        @(posedge clk); #1;
        stream_en = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 18'h30000;
        repeat (10) @(negedge clk);
        check("te_blocked_starts", bus_starts - s0, 0);
        check("te_blocked_busy", busy, 0);
        @(posedge clk); #3;
        lcd_fmark = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        check("te_latency_ok", n <= 4, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_ready && n < 50);
        check("te_pix_ready", pix_ready, 1);
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0; lcd_fmark = 1'b0;
        wait_idle();
`endif

        repeat (4) @(negedge clk);
        check("bus_queue_empty", exp_bus.size(), 0);
        check("ack_queue_empty", exp_ack.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
